// File: rtl/snake_pkg.sv
// Shared heading type, keycode constants and the reversal helper for the
// keyboard-to-steering path.
package snake_pkg;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_STOP  = 3'd4
  } dir_t;

  localparam logic [7:0] KC_W     = 8'h1A;
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_S     = 8'h16;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_D     = 8'h07;
  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_SPACE = 8'h2C;

  // STOP has no opposite; returning STOP keeps it from matching any key heading.
  function automatic dir_t opposite(input dir_t d);
    case (d)
      DIR_UP:    opposite = DIR_DOWN;
      DIR_DOWN:  opposite = DIR_UP;
      DIR_LEFT:  opposite = DIR_RIGHT;
      DIR_RIGHT: opposite = DIR_LEFT;
      default:   opposite = DIR_STOP;
    endcase
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Circular buffer of pending headings; head is visible on dout, a pop on the
// same cycle as a push frees a slot so a full buffer can still accept.
module dir_fifo
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  dir_t          din,
  output dir_t          dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dir_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is plain binary rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/key_direction_queue.sv
// Converts raw keycodes into queued steering turns and releases one turn per
// VGA frame; also owns the pause toggle and a sticky overflow flag.
module key_direction_queue
  import snake_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  input  logic          frame_vs,
  output logic [2:0]    Direction,
  output logic          Turn,
  output logic          Paused,
  output logic [CW-1:0] Count,
  output logic          Overflow
);

  logic [7:0] key_q;
  logic       is_dir;
  logic       is_pause;
  logic       press;
  dir_t       key_dir;
  dir_t       last_dir;
  dir_t       head;
  dir_t       dir_q;
  logic       vs_s1, vs_s2, vs_s3;
  logic       tick;
  logic       accept;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;

  always_comb begin
    is_dir   = 1'b0;
    is_pause = 1'b0;
    key_dir  = DIR_STOP;
    case (keycode)
      KC_W, KC_UP: begin
        is_dir  = 1'b1;
        key_dir = DIR_UP;
      end
      KC_S, KC_DOWN: begin
        is_dir  = 1'b1;
        key_dir = DIR_DOWN;
      end
      KC_A, KC_LEFT: begin
        is_dir  = 1'b1;
        key_dir = DIR_LEFT;
      end
      KC_D, KC_RIGHT: begin
        is_dir  = 1'b1;
        key_dir = DIR_RIGHT;
      end
      KC_SPACE: is_pause = 1'b1;
      default: ;
    endcase
  end

  assign press  = (keycode != key_q) && (is_dir || is_pause);
  // Compared against the last accepted heading, not the one currently applied.
  assign accept = press && is_dir && !Paused &&
                  (key_dir != last_dir) && (key_dir != opposite(last_dir));

  assign tick = vs_s2 & ~vs_s3;
  assign pop  = tick && !Paused && !empty;
  assign push = accept && (!full || pop);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      key_q    <= 8'h00;
      vs_s1    <= 1'b0;
      vs_s2    <= 1'b0;
      vs_s3    <= 1'b0;
      Paused   <= 1'b0;
      last_dir <= DIR_STOP;
      dir_q    <= DIR_STOP;
      Turn     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      key_q <= keycode;
      vs_s1 <= frame_vs;
      vs_s2 <= vs_s1;
      vs_s3 <= vs_s2;
      Turn  <= pop;
      if (press && is_pause)         Paused   <= ~Paused;
      if (push)                      last_dir <= key_dir;
      if (pop)                       dir_q    <= head;
      if (accept && full && !pop)    Overflow <= 1'b1;
    end
  end

  assign Direction = dir_q;

  dir_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (Clk),
    .rst   (Reset),
    .push  (push),
    .pop   (pop),
    .din   (key_dir),
    .dout  (head),
    .count (Count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_key_direction_queue.sv
// Bench for key_direction_queue: vector table, directed corner sequences and a
// randomized run compared every cycle against a queue-based reference model.
`timescale 1ns/1ps
module tb_key_direction_queue;

  localparam int DEPTH = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       frame_vs = 1'b0;
  logic [2:0] Direction;
  logic       Turn;
  logic       Paused;
  logic [2:0] Count;
  logic       Overflow;

  int total = 0;
  int bad = 0;

  key_direction_queue #(.DEPTH(DEPTH), .CW(3)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .keycode   (keycode),
    .frame_vs  (frame_vs),
    .Direction (Direction),
    .Turn      (Turn),
    .Paused    (Paused),
    .Count     (Count),
    .Overflow  (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pending turns in a queue, headings as 0..3 with 4 = stop.
  int m_q[$];
  int m_last, m_dir, m_turn, m_paused, m_ovf, m_kprev;
  int fvh[$];

  function automatic int kmap(input logic [7:0] kc);
    case (kc)
      8'h1A, 8'h52: return 0;
      8'h16, 8'h51: return 1;
      8'h04, 8'h50: return 2;
      8'h07, 8'h4F: return 3;
      8'h2C:        return 5;
      default:      return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_last = 4; m_dir = 4; m_turn = 0; m_paused = 0; m_ovf = 0; m_kprev = 0;
    fvh = '{0, 0, 0};
  endtask

  // One clock edge: frame_vs seen two edges ago high and three edges ago low
  // means the heading loads on this edge.
  task automatic model_edge();
    int  k = kmap(keycode);
    bit  press = (int'(keycode) != m_kprev) && (k >= 0);
    bit  tick = (fvh[1] == 1) && (fvh[2] == 0);
    bit  was_paused = (m_paused != 0);
    bit  popped = tick && !was_paused && (m_q.size() > 0);
    m_turn = int'(popped);
    if (popped) m_dir = m_q.pop_front();
    if (press && k == 5) m_paused = was_paused ? 0 : 1;
    if (press && k < 4 && !was_paused && k != m_last && !(m_last != 4 && k == (m_last ^ 1))) begin
      if (m_q.size() < DEPTH) begin
        m_q.push_back(k);
        m_last = k;
      end else begin
        m_ovf = 1;
      end
    end
    fvh.push_front(int'(frame_vs));
    void'(fvh.pop_back());
    m_kprev = int'(keycode);
  endtask

  task automatic step(input logic [7:0] kc, input logic fv);
    keycode  = kc;
    frame_vs = fv;
    model_edge();
    @(posedge Clk);
    #1;
    check("model", {Direction, Turn, Paused, Count, Overflow},
          {3'(m_dir), m_turn[0], m_paused[0], 3'(m_q.size()), m_ovf[0]});
  endtask

  // Reset asserted mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    Reset = 1'b1; keycode = 8'h00; frame_vs = 1'b0;
    model_reset();
    #1;
    check("reset", {Direction, Turn, Paused, Count, Overflow}, {3'd4, 1'b0, 1'b0, 3'd0, 1'b0});
    @(posedge Clk);
    #1;
    Reset = 1'b0;
  endtask

  task automatic vs_pulse(input logic [7:0] kc, output int turns);
    turns = 0;
    step(kc, 1'b1);
    if (Turn === 1'b1) turns++;
    for (int i = 0; i < 4; i++) begin
      step(kc, 1'b0);
      if (Turn === 1'b1) turns++;
    end
  endtask

  task automatic seq(input logic [7:0] codes[$]);
    foreach (codes[i]) step(codes[i], 1'b0);
  endtask

  typedef struct {
    logic [7:0] kc;
    logic       fv;
    logic [2:0] dir;
    logic       turn;
    logic [2:0] cnt;
    logic       ovf;
  } vec_t;

  vec_t tbl[14];
  logic [7:0] pool[13];
  int exp_dir[4];
  int t, tsum, hold;

  initial begin
    tbl[0]  = '{8'h07, 1'b0, 3'd4, 1'b0, 3'd1, 1'b0};
    tbl[1]  = '{8'h07, 1'b1, 3'd4, 1'b0, 3'd1, 1'b0};
    tbl[2]  = '{8'h07, 1'b1, 3'd4, 1'b0, 3'd1, 1'b0};
    tbl[3]  = '{8'h07, 1'b0, 3'd3, 1'b1, 3'd0, 1'b0};
    tbl[4]  = '{8'h07, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    tbl[5]  = '{8'h04, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    tbl[6]  = '{8'h07, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    tbl[7]  = '{8'h00, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    tbl[8]  = '{8'h07, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0};
    tbl[9]  = '{8'h1A, 1'b0, 3'd3, 1'b0, 3'd1, 1'b0};
    tbl[10] = '{8'h52, 1'b0, 3'd3, 1'b0, 3'd1, 1'b0};
    tbl[11] = '{8'h16, 1'b0, 3'd3, 1'b0, 3'd1, 1'b0};
    tbl[12] = '{8'h99, 1'b0, 3'd3, 1'b0, 3'd1, 1'b0};
    tbl[13] = '{8'h50, 1'b0, 3'd3, 1'b0, 3'd2, 1'b0};
    pool = '{8'h00, 8'h1A, 8'h52, 8'h16, 8'h51, 8'h04, 8'h50, 8'h07, 8'h4F,
             8'h2C, 8'h00, 8'h00, 8'h33};
    exp_dir = '{0, 2, 1, 3};

    // Single turn through one frame, then reversal / duplicate rejection.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      step(tbl[i].kc, tbl[i].fv);
      check($sformatf("vec%0d", i), {Direction, Turn, Count, Overflow},
            {tbl[i].dir, tbl[i].turn, tbl[i].cnt, tbl[i].ovf});
    end

    // Five presses in one frame: fifth dropped, then drained in order.
    do_reset();
    seq('{8'h1A, 8'h00, 8'h04, 8'h00, 8'h16, 8'h00, 8'h07, 8'h00, 8'h1A});
    check("fill_count", Count, 3'd4);
    check("fill_ovf", Overflow, 1'b1);
    for (int p = 0; p < 4; p++) begin
      vs_pulse(8'h1A, t);
      check($sformatf("drain%0d_turns", p), t, 1);
      check($sformatf("drain%0d_dir", p), Direction, exp_dir[p]);
    end
    check("drain_count", Count, 3'd0);
    check("drain_ovf", Overflow, 1'b1);

    // Full FIFO with a press landing on the tick edge.
    do_reset();
    seq('{8'h1A, 8'h00, 8'h04, 8'h00, 8'h16, 8'h00, 8'h07});
    check("full_count", Count, 3'd4);
    step(8'h07, 1'b1);
    step(8'h07, 1'b0);
    step(8'h1A, 1'b0);
    check("pushpop", {Turn, Direction, Count, Overflow}, {1'b1, 3'd0, 3'd4, 1'b0});

    // Pause blocks both new presses and frame releases.
    do_reset();
    step(8'h2C, 1'b0);
    check("pause_on", Paused, 1'b1);
    step(8'h1A, 1'b0);
    check("pause_count", Count, 3'd0);
    tsum = 0;
    for (int p = 0; p < 3; p++) begin
      vs_pulse(8'h1A, t);
      tsum += t;
    end
    check("pause_turns", tsum, 0);
    check("pause_dir", Direction, 3'd4);
    step(8'h00, 1'b0);
    step(8'h2C, 1'b0);
    check("pause_off", Paused, 1'b0);

    // Reset with turns pending discards them.
    do_reset();
    seq('{8'h1A, 8'h00, 8'h04, 8'h00, 8'h16});
    check("pre_reset_count", Count, 3'd3);
    do_reset();
    vs_pulse(8'h00, t);
    check("post_reset_turns", t, 0);
    check("post_reset_dir", Direction, 3'd4);

    // Randomized traffic against the model, with periodic resets.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 1000 == 999) do_reset();
      if (hold == 0) begin
        keycode = pool[$urandom_range(0, 12)];
        hold = $urandom_range(1, 4);
      end
      hold--;
      step(keycode, ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
